// File: rtl/seg_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg_scan_decoder
//
// Recovers digit values from a time-multiplexed, active-low 7-segment bus.
// One shared segment bus is scanned across NUM_DIGITS digits by active-low
// anode selects. Each digit's pattern must be seen unchanged for
// STABLE_CYCLES consecutive samples before it is committed. A commit
// updates the digit value and its DP, blank and error flags. The block also
// raises a frame strobe once every digit has been refreshed, and a stale
// flag when the bus has gone STALE_CYCLES cycles without a commit.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          synchronous active-low reset
//   seg_n[7:0]     active-low segments; bit7 = DP, bits6..0 = g..a
//   an_n[N-1:0]    active-low anode selects; bit i low selects digit i
//   digits_o       digit i value at [4i+3:4i]
//   dp_o           DP lit for digit i at its last commit
//   blank_o        digit i was blank at its last commit
//   err_o          digit i pattern was undecodable at its last commit
//   frame_valid_o  one-cycle pulse when every digit has committed since the
//                  previous pulse
//   stale_o        no commit for STALE_CYCLES cycles
// ---------------------------------------------------------------------------
module seg_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int HEX_EN        = 0,
    parameter int STALE_CYCLES  = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
    output logic [4*NUM_DIGITS-1:0] digits_o,
    output logic [NUM_DIGITS-1:0]   dp_o,
    output logic [NUM_DIGITS-1:0]   blank_o,
    output logic [NUM_DIGITS-1:0]   err_o,
    output logic                    frame_valid_o,
    output logic                    stale_o
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int SW = $clog2(STALE_CYCLES + 1);
    localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_CYCLES);
    localparam logic [SW-1:0] STALE_MAX  = SW'(STALE_CYCLES);
    localparam logic          HEX_ON     = (HEX_EN != 0);

    // Decode a 7-bit active-low pattern into {err, blank, digit[3:0]}.
    function automatic logic [5:0] decode_seg(input logic [6:0] pat,
                                              input logic       hex_on);
        logic [5:0] r;
        r = {1'b1, 1'b0, 4'hF};
        case (pat)
            7'h40:   r = {2'b00, 4'h0};
            7'h79:   r = {2'b00, 4'h1};
            7'h24:   r = {2'b00, 4'h2};
            7'h30:   r = {2'b00, 4'h3};
            7'h19:   r = {2'b00, 4'h4};
            7'h12:   r = {2'b00, 4'h5};
            7'h02:   r = {2'b00, 4'h6};
            7'h78:   r = {2'b00, 4'h7};
            7'h00:   r = {2'b00, 4'h8};
            7'h10:   r = {2'b00, 4'h9};
            7'h08:   r = hex_on ? {2'b00, 4'hA} : {2'b10, 4'hF};
            7'h03:   r = hex_on ? {2'b00, 4'hB} : {2'b10, 4'hF};
            7'h46:   r = hex_on ? {2'b00, 4'hC} : {2'b10, 4'hF};
            7'h21:   r = hex_on ? {2'b00, 4'hD} : {2'b10, 4'hF};
            7'h06:   r = hex_on ? {2'b00, 4'hE} : {2'b10, 4'hF};
            7'h0E:   r = hex_on ? {2'b00, 4'hF} : {2'b10, 4'hF};
            7'h7F:   r = {2'b01, 4'hF};
            default: r = {2'b10, 4'hF};
        endcase
        return r;
    endfunction

    // True when exactly one bit of the vector is set.
    function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
        return (v != '0) && ((v & (v - NUM_DIGITS'(1))) == '0);
    endfunction

    logic [7:0]              prev_seg_q, prev_seg_d;
    logic [NUM_DIGITS-1:0]   prev_an_q, prev_an_d;
    logic [CW-1:0]           run_q, run_d;
    logic [SW-1:0]           stale_cnt_q, stale_cnt_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic [NUM_DIGITS-1:0]   err_q, err_d;
    logic                    frame_q, frame_d;
    logic                    stale_q, stale_d;

    logic [NUM_DIGITS-1:0]   an_low_s;
    logic                    valid_s;
    logic                    same_s;
    logic                    commit_s;
    logic [5:0]              decoded_s;
    logic [NUM_DIGITS-1:0]   seen_next_s;

    // Sample qualification, run counting and commit detection.
    always_comb begin
        an_low_s   = ~an_n;
        valid_s    = is_onehot(an_low_s);
        same_s     = ({seg_n, an_n} == {prev_seg_q, prev_an_q});
        prev_seg_d = seg_n;
        prev_an_d  = an_n;

        if (!valid_s) begin
            run_d = '0;
        end else if (!same_s) begin
            run_d = CW'(1);
        end else if (run_q == STABLE_MAX) begin
            run_d = run_q;
        end else begin
            run_d = run_q + CW'(1);
        end

        // A saturated, unchanged dwell must not commit again; a changed
        // sample with STABLE_CYCLES == 1 commits immediately.
        commit_s  = valid_s && (run_d == STABLE_MAX) &&
                    ((run_q != STABLE_MAX) || !same_s);
        decoded_s = decode_seg(seg_n[6:0], HEX_ON);
    end

    // Per-digit output update and frame tracking on commit.
    always_comb begin
        digits_d    = digits_q;
        dp_d        = dp_q;
        blank_d     = blank_q;
        err_d       = err_q;
        seen_d      = seen_q;
        frame_d     = 1'b0;
        seen_next_s = seen_q | an_low_s;

        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (commit_s && an_low_s[i]) begin
                digits_d[4*i +: 4] = decoded_s[3:0];
                dp_d[i]            = ~seg_n[7];
                blank_d[i]         = decoded_s[4];
                err_d[i]           = decoded_s[5];
            end else begin
                digits_d[4*i +: 4] = digits_q[4*i +: 4];
            end
        end

        if (commit_s) begin
            // Completing the mask fires the strobe and starts a new frame.
            if (&seen_next_s) begin
                frame_d = 1'b1;
                seen_d  = '0;
            end else begin
                seen_d  = seen_next_s;
            end
        end else begin
            seen_d = seen_q;
        end
    end

    // Stale-bus counter: cleared by any commit, otherwise saturating.
    always_comb begin
        if (commit_s) begin
            stale_cnt_d = '0;
            stale_d     = 1'b0;
        end else begin
            if (stale_cnt_q == STALE_MAX) begin
                stale_cnt_d = stale_cnt_q;
            end else begin
                stale_cnt_d = stale_cnt_q + SW'(1);
            end
            stale_d = (stale_cnt_d == STALE_MAX);
        end
    end

    // State and registered outputs; reset returns the bus history to idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_seg_q  <= 8'hFF;
            prev_an_q   <= '1;
            run_q       <= '0;
            stale_cnt_q <= '0;
            seen_q      <= '0;
            digits_q    <= '0;
            dp_q        <= '0;
            blank_q     <= '0;
            err_q       <= '0;
            frame_q     <= 1'b0;
            stale_q     <= 1'b0;
        end else begin
            prev_seg_q  <= prev_seg_d;
            prev_an_q   <= prev_an_d;
            run_q       <= run_d;
            stale_cnt_q <= stale_cnt_d;
            seen_q      <= seen_d;
            digits_q    <= digits_d;
            dp_q        <= dp_d;
            blank_q     <= blank_d;
            err_q       <= err_d;
            frame_q     <= frame_d;
            stale_q     <= stale_d;
        end
    end

    assign digits_o      = digits_q;
    assign dp_o          = dp_q;
    assign blank_o       = blank_q;
    assign err_o         = err_q;
    assign frame_valid_o = frame_q;
    assign stale_o       = stale_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_decoder
//
// Directed bench for seg_scan_decoder (4 digits, 4-sample filter, 16-cycle
// stale limit). A decimal-mode instance is the main target; a hex-mode
// instance shares the same stimulus for the A-F decode check. Expected
// output snapshots are queued as each dwell is driven and compared on the
// cycle the commit is due.
// ---------------------------------------------------------------------------
module tb_seg_scan_decoder;

    localparam int ND    = 4;
    localparam int STAB  = 4;
    localparam int STALE = 16;

    logic          clk;
    logic          rst_n;
    logic [7:0]    seg_n;
    logic [ND-1:0] an_n;

    logic [4*ND-1:0] digits_o, h_digits;
    logic [ND-1:0]   dp_o, blank_o, err_o, h_dp, h_blank, h_err;
    logic            frame_valid_o, stale_o, h_frame, h_stale;

    seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(STAB), .HEX_EN(0),
                       .STALE_CYCLES(STALE)) dut (
        .clk(clk), .rst_n(rst_n), .seg_n(seg_n), .an_n(an_n),
        .digits_o(digits_o), .dp_o(dp_o), .blank_o(blank_o), .err_o(err_o),
        .frame_valid_o(frame_valid_o), .stale_o(stale_o)
    );

    seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(STAB), .HEX_EN(1),
                       .STALE_CYCLES(STALE)) dut_hex (
        .clk(clk), .rst_n(rst_n), .seg_n(seg_n), .an_n(an_n),
        .digits_o(h_digits), .dp_o(h_dp), .blank_o(h_blank), .err_o(h_err),
        .frame_valid_o(h_frame), .stale_o(h_stale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  dp;
        logic [3:0]  bl;
        logic [3:0]  er;
        logic        fr;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] exp_d;
    logic [3:0]  exp_dp, exp_bl, exp_er;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Record the expected state after a commit to digit k and queue it.
    task automatic push(input int k, input logic [3:0] val, input logic dp,
                        input logic bl, input logic er, input logic fr);
        exp_t e;
        exp_d[4*k +: 4] = val;
        exp_dp[k] = dp;
        exp_bl[k] = bl;
        exp_er[k] = er;
        e.d = exp_d; e.dp = exp_dp; e.bl = exp_bl; e.er = exp_er; e.fr = fr;
        sb.push_back(e);
    endtask

    // Drive one sample for n cycles; at cycle commit_at pop and compare.
    task automatic hold(input logic [3:0] an, input logic [7:0] seg,
                        input int n, input int commit_at);
        exp_t e;
        for (int i = 1; i <= n; i++) begin
            an_n  = an;
            seg_n = seg;
            @(posedge clk);
            #1;
            if (i == commit_at) begin
                if (sb.size() == 0) begin
                    check("scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("digits", 32'(digits_o), 32'(e.d));
                    check("dp", 32'(dp_o), 32'(e.dp));
                    check("blank", 32'(blank_o), 32'(e.bl));
                    check("err", 32'(err_o), 32'(e.er));
                    check("frame", 32'(frame_valid_o), 32'(e.fr));
                    check("stale_at_commit", 32'(stale_o), 32'd0);
                end
            end else begin
                check("no_frame", 32'(frame_valid_o), 32'd0);
            end
        end
    endtask

    task automatic idle(input int n);
        hold(4'hF, 8'hFF, n, 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_digits"}, 32'(digits_o), 32'd0);
        check({tag, "_dp"}, 32'(dp_o), 32'd0);
        check({tag, "_blank"}, 32'(blank_o), 32'd0);
        check({tag, "_err"}, 32'(err_o), 32'd0);
        check({tag, "_frame"}, 32'(frame_valid_o), 32'd0);
        check({tag, "_stale"}, 32'(stale_o), 32'd0);
    endtask

    initial begin
        exp_d = 16'h0000; exp_dp = 4'h0; exp_bl = 4'h0; exp_er = 4'h0;
        rst_n = 1'b0;
        an_n  = 4'hF;
        seg_n = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        rst_n = 1'b1;

        // Single digit 0, exactly four samples.
        push(0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        hold(4'b1110, 8'hC0, 4, 4);

        // Full scan 1,2,3,4 with blanking between digits.
        idle(1);
        push(0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
        hold(4'b1110, 8'hF9, 6, 4);
        idle(1);
        push(1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
        hold(4'b1101, 8'hA4, 6, 4);
        idle(1);
        push(2, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
        hold(4'b1011, 8'hB0, 6, 4);
        idle(1);
        push(3, 4'h4, 1'b0, 1'b0, 1'b0, 1'b1);
        hold(4'b0111, 8'h99, 6, 4);
        check("scan_value", 32'(digits_o), 32'h4321);

        // Pattern 'A' on digit 2: error in decimal mode, valid in hex mode.
        idle(1);
        push(2, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
        hold(4'b1011, 8'h88, 4, 4);
        check("hex_digit2", 32'(h_digits[11:8]), 32'hA);
        check("hex_err2", 32'(h_err[2]), 32'd0);

        // DP change restarts the run; commit only after four 8'h92 samples.
        idle(1);
        hold(4'b1101, 8'h12, 3, 0);
        push(1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0);
        hold(4'b1101, 8'h92, 4, 4);

        // Two anodes low: never a valid sample.
        idle(1);
        hold(4'b1100, 8'h12, 3, 0);
        hold(4'b1100, 8'h92, 4, 0);
        check("multi_an_digits", 32'(digits_o), 32'(exp_d));
        check("multi_an_dp", 32'(dp_o), 32'(exp_dp));

        // DP lit on digit 0.
        idle(1);
        push(0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        hold(4'b1110, 8'h40, 4, 4);

        // Blank digit 3 completes the frame (digits 0,1,2 already seen).
        idle(1);
        push(3, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1);
        hold(4'b0111, 8'hFF, 4, 4);

        // Idle bus: stale asserts on the STALE-th non-commit edge.
        idle(STALE - 1);
        check("stale_early", 32'(stale_o), 32'd0);
        idle(1);
        check("stale_set", 32'(stale_o), 32'd1);
        hold(4'b1110, 8'hC0, 3, 0);
        check("stale_held", 32'(stale_o), 32'd1);
        push(0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        hold(4'b1110, 8'hC0, 1, 1);

        // Reset mid-dwell and mid-frame (digit 0 already seen).
        idle(1);
        hold(4'b1101, 8'hC0, 2, 0);
        rst_n = 1'b0;
        hold(4'b1101, 8'hC0, 1, 0);
        check_reset("midreset");
        rst_n = 1'b1;
        exp_d = 16'h0000; exp_dp = 4'h0; exp_bl = 4'h0; exp_er = 4'h0;

        // Following scan: frame fires only when digit 0 completes it.
        push(1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        hold(4'b1101, 8'hC0, 4, 4);
        idle(1);
        push(2, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
        hold(4'b1011, 8'hF9, 5, 4);
        idle(1);
        push(3, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
        hold(4'b0111, 8'hA4, 5, 4);
        idle(1);
        push(0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1);
        hold(4'b1110, 8'hB0, 5, 4);
        idle(2);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        check("final_digits", 32'(digits_o), 32'h2103);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
